// File: rtl/prog_loader.sv
// Instruction-memory loader: parses a SYNC/count/words/checksum byte frame,
// writes the words to IMEM from address 0, and releases the CPU only on a valid image.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | hunting for SYNC, other bytes dropped
// S_CNT_HI | expecting word count [15:8]
// S_CNT_LO | expecting word count [7:0], range check
// S_DATA   | assembling big-endian words, writing IMEM
// S_CHECK  | expecting XOR checksum of data bytes
// S_DONE   | image valid, CPU released (sticky)
// S_ERR    | load failed (sticky)
module prog_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              cpu_run,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       count_q;
  logic [ADDR_W:0]   word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        csum_q;
  logic [23:0]       shift_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        accept;
  logic [15:0] cnt_full;
  logic [16:0] word_next;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign cnt_full  = {count_q[15:8], in_data};
  assign word_next = 17'(word_idx_q) + 17'd1;
  assign last_word = (byte_idx_q == 2'd3) && (word_next == {1'b0, count_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && in_data == SYNC) state_d = S_CNT_HI;
      S_CNT_HI: if (accept) state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (accept) begin
          if ({1'b0, cnt_full} > MAX_WORDS) state_d = S_ERR;
          else if (cnt_full == 16'd0)       state_d = S_CHECK;
          else                              state_d = S_DATA;
        end
      end
      S_DATA:   if (accept && last_word) state_d = S_CHECK;
      S_CHECK:  if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    cpu_run  = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE:                     in_ready = 1'b1;
      S_CNT_HI, S_CNT_LO,
      S_DATA, S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:                     cpu_run  = 1'b1;
      S_ERR:                      err      = 1'b1;
      default:                    in_ready = 1'b0;
    endcase
  end

  // Datapath: count capture, word assembly and the one-cycle-late write pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_CNT_HI: count_q[15:8] <= in_data;
          S_CNT_LO: begin
            count_q[7:0] <= in_data;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
          end
          S_DATA: begin
            csum_q     <= csum_q ^ in_data;
            shift_q    <= {shift_q[15:0], in_data};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              we_q       <= 1'b1;
              wdata_q    <= {shift_q, in_data};
              addr_q     <= word_idx_q[ADDR_W-1:0];
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule
